window_3x3_gen: RTL and testbench
=================================

// Module: window_3x3_gen
// PURPOSE
//  Streaming 3x3 sliding-window generator. It sits directly upstream of the 3x3 filter-apply stage.
//  - Accepts one 32-bit FP pixel per valid cycle, in raster order (row-major, top-left first).
//  - Buffers the two previous rows internally.
//  - Emits the nine pixels of each full 3x3 window plus a valid strobe, which drive data_in_0..8 and input_valid.
//  - "Valid" convolution only: no padding, so (IMG_W-2)*(IMG_H-2) windows per frame.
// PARAMETERS
//  IMG_W   28  pixels per row (>=3)
//  IMG_H   28  rows per frame (>=3)
//  DATA_W  32  pixel width (IEEE-754 single; bits are never interpreted)
// PORTS
//  clk         in   1       single clock; all state updates on posedge clk
//  rst         in   1       synchronous, active-high reset
//  in_valid    in   1       in_data carries the next raster pixel this cycle
//  in_data     in   DATA_W  pixel value
//  out_valid   out  1       win_0..win_8 hold a complete window this cycle
//  win_0..8    out  DATA_W  window, row-major: win_0=(r-2,c-2) ... win_4=(r-1,c-1) ... win_8=(r,c)
//  frame_done  out  1       1-cycle pulse, coincident with the out_valid of the frame's last window
// BEHAVIOUR
//  - Reset: out_valid=0, frame_done=0, win_0..8=0, col/row counters=0.
//     - Line-buffer RAM is not cleared; its contents are never exposed before a refill.
//  - No backpressure; the consumer always accepts.
//     - in_valid=0 cycles freeze all state; gaps of any length are allowed.
//     - out_valid=0 in any cycle after an in_valid=0 cycle.
//  - Counters: col 0..IMG_W-1 and row 0..IMG_H-1, both advanced by accepted pixels.
//     - col wraps to 0 and row increments at col=IMG_W-1.
//     - At (IMG_H-1, IMG_W-1) both wrap to 0; the next pixel starts a new frame.
//  - Data path per accepted pixel at (r,c):
//     - Read line buffers at address c: lb1 = row r-1, lb0 = row r-2.
//     - Shift the 3x3 register array left by one column; the new right column is {lb0[c], lb1[c], in_data}.
//     - Write lb0[c] <= lb1[c] and lb1[c] <= in_data (read-before-write at the same address).
//  - Emission: out_valid=1 exactly one cycle after accepting pixel (r,c) with r>=2 and c>=2.
//     - Latency is one cycle, registered.
//     - Pixels with c<2 produce no window, so no window ever spans a row wrap.
//     - Pixels with r<2 produce no window, so no window ever spans a frame boundary.
//  - When out_valid=0, win_* hold their last value; the consumer ignores them.
//  - frame_done: asserted together with out_valid for the pixel at (IMG_H-1, IMG_W-1).
//  - Reset mid-frame: the next cycle shows reset values. The next accepted pixel is (0,0) of a new frame.
//  - rst and in_valid high together: reset wins, and the pixel is dropped.
//  - Widths: col is $clog2(IMG_W) bits, row is $clog2(IMG_H) bits. No arithmetic is performed on data.
// STRUCTURE
//  - Shared include cnn_defs.vh holds:
//     - DATA_W
//     - default IMG_W/IMG_H for each layer
//     - localparams for window tap indices (TAP_TL=0 .. TAP_BR=8), shared with filter_apply.
//  - Sub-module line_buffer #(DEPTH=IMG_W, DATA_W).
//     - Synchronous-write, single-address RAM with read-before-write.
//     - Instantiated twice (lb0, lb1) or once as 2*DATA_W wide.
//  - Top level holds the counters, the 3x3 register array, emission and frame_done logic.
// TESTING  (IMG_W=IMG_H=5; pixel (r,c) value = 5r+c+1, i.e. 1..25)
//  1. Continuous in_valid, one frame.
//     - Exactly 9 out_valid pulses.
//     - First pulse is the cycle after pixel 13, with win_0..8 = 1,2,3,6,7,8,11,12,13.
//     - Last pulse is the window 13,14,15,18,19,20,23,24,25, with frame_done=1.
//  2. Same frame with random 0..4-cycle in_valid gaps -> identical 9-window sequence; out_valid never 2 cycles in a row across a gap.
//  3. Two back-to-back frames (second: values +100).
//     - Second-frame windows start only after its pixel 13.
//     - No window mixes frame-1 and frame-2 values.
//  4. rst pulse after 17 pixels.
//     - Next cycle: out_valid=0, frame_done=0, win_*=0.
//     - A fresh frame then reproduces scenario 1 exactly.
//  5. Row-wrap check: pixels at c=0,1 of rows 2..4 (values 11,12,16,17,21,22) never produce an out_valid cycle.
//  6. Default 28x28: exactly 676 windows and one frame_done per frame. rst held with in_valid=1 -> no out_valid.

Source files
------------

// File: rtl/window_3x3_gen_pkg.sv
// Shared definitions for the 3x3 window generator and its consumer (filter_apply).
//  - CNN_DATA_W  : pixel width (IEEE-754 single, never interpreted here)
//  - CNN_IMG_W/H : default layer geometry
//  - TAP_*       : row-major window tap indices, TAP_TL=(r-2,c-2) .. TAP_BR=(r,c)
package window_3x3_gen_pkg;

    localparam int CNN_DATA_W = 32;

    localparam int CNN_IMG_W = 28;
    localparam int CNN_IMG_H = 28;

    localparam int N_TAPS = 9;
    localparam int TAP_TL = 0;
    localparam int TAP_TC = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int TAP_MC = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BC = 7;
    localparam int TAP_BR = 8;

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One image row of pixel storage.
//  - Single address shared by read and write; the read is combinational, so a
//    read and a write to the same address in one cycle return the old contents.
// Ports:
//  clk      clock
//  wr_en    write wr_data at addr on the rising edge
//  addr     column address
//  wr_data  value to store
//  rd_data  current contents at addr
module line_buffer #(
    parameter int DEPTH  = window_3x3_gen_pkg::CNN_IMG_W,
    parameter int DATA_W = window_3x3_gen_pkg::CNN_DATA_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Not reset: contents are always overwritten by a full row before they
    // can reach a window.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 sliding-window generator ("valid" convolution, no padding).
// Takes one raster-order pixel per in_valid cycle, keeps the two previous rows
// in line buffers and presents each complete 3x3 window one cycle after its
// bottom-right pixel is accepted.
// Ports:
//  clk         clock
//  rst         synchronous active-high reset
//  in_valid    in_data holds the next raster pixel
//  in_data     pixel value
//  out_valid   win_0..win_8 hold a complete window
//  win_0..8    window, row-major, win_0=(r-2,c-2), win_4=(r-1,c-1), win_8=(r,c)
//  frame_done  pulse with the last window of a frame
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int IMG_W  = CNN_IMG_W,
    parameter int IMG_H  = CNN_IMG_H,
    parameter int DATA_W = CNN_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] win_0,
    output logic [DATA_W-1:0] win_1,
    output logic [DATA_W-1:0] win_2,
    output logic [DATA_W-1:0] win_3,
    output logic [DATA_W-1:0] win_4,
    output logic [DATA_W-1:0] win_5,
    output logic [DATA_W-1:0] win_6,
    output logic [DATA_W-1:0] win_7,
    output logic [DATA_W-1:0] win_8,
    output logic              frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] win_q [N_TAPS];
    logic [DATA_W-1:0] lb0_rd;
    logic [DATA_W-1:0] lb1_rd;
    logic              accept;

    // A pixel presented during reset is dropped, including from the line buffers.
    assign accept = in_valid && !rst;

    // lb1 holds row r-1, lb0 holds row r-2; each accepted pixel ages the
    // column down by one row.
    line_buffer #(
        .DEPTH  (IMG_W),
        .DATA_W (DATA_W),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col),
        .wr_data (lb1_rd),
        .rd_data (lb0_rd)
    );

    line_buffer #(
        .DEPTH  (IMG_W),
        .DATA_W (DATA_W),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col),
        .wr_data (in_data),
        .rd_data (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            // Windows only for c>=2 and r>=2, so none ever straddles a row
            // wrap or a frame boundary; stale taps are simply never flagged.
            out_valid  <= in_valid && (row >= ROW_FIRST) && (col >= COL_FIRST);
            frame_done <= in_valid && (row == ROW_LAST) && (col == COL_LAST);

            if (in_valid) begin
                win_q[TAP_TL] <= win_q[TAP_TC];
                win_q[TAP_TC] <= win_q[TAP_TR];
                win_q[TAP_TR] <= lb0_rd;
                win_q[TAP_ML] <= win_q[TAP_MC];
                win_q[TAP_MC] <= win_q[TAP_MR];
                win_q[TAP_MR] <= lb1_rd;
                win_q[TAP_BL] <= win_q[TAP_BC];
                win_q[TAP_BC] <= win_q[TAP_BR];
                win_q[TAP_BR] <= in_data;

                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_ONE;
                end else begin
                    col <= col + COL_ONE;
                end
            end
        end
    end

    assign win_0 = win_q[TAP_TL];
    assign win_1 = win_q[TAP_TC];
    assign win_2 = win_q[TAP_TR];
    assign win_3 = win_q[TAP_ML];
    assign win_4 = win_q[TAP_MC];
    assign win_5 = win_q[TAP_MR];
    assign win_6 = win_q[TAP_BL];
    assign win_7 = win_q[TAP_BC];
    assign win_8 = win_q[TAP_BR];

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int BW = 28;
    localparam int BH = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_valid, frame_done;
    logic [31:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;

    logic        b_in_valid = 1'b0;
    logic [31:0] b_in_data = '0;
    logic        b_out_valid, b_frame_done;
    logic [31:0] b_win_0, b_win_1, b_win_2, b_win_3, b_win_4, b_win_5, b_win_6, b_win_7, b_win_8;

    logic [31:0] win_s   [9];
    logic [31:0] b_win_s [9];

    int n_pass  = 0;
    int n_total = 0;

    // small-frame reference model: stores the frame as a 2D image and cuts
    // the window directly out of it
    logic [31:0] img [H][W];
    int          m_r = 0;
    int          m_c = 0;
    bit          exp_valid = 0;
    bit          exp_done = 0;
    logic [31:0] exp_win [9];

    always #5 clk = ~clk;

    window_3x3_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid),
        .win_0(win_0), .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4),
        .win_5(win_5), .win_6(win_6), .win_7(win_7), .win_8(win_8),
        .frame_done(frame_done)
    );

    window_3x3_gen dut_big (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .out_valid(b_out_valid),
        .win_0(b_win_0), .win_1(b_win_1), .win_2(b_win_2), .win_3(b_win_3), .win_4(b_win_4),
        .win_5(b_win_5), .win_6(b_win_6), .win_7(b_win_7), .win_8(b_win_8),
        .frame_done(b_frame_done)
    );

    assign win_s[0] = win_0;  assign win_s[1] = win_1;  assign win_s[2] = win_2;
    assign win_s[3] = win_3;  assign win_s[4] = win_4;  assign win_s[5] = win_5;
    assign win_s[6] = win_6;  assign win_s[7] = win_7;  assign win_s[8] = win_8;
    assign b_win_s[0] = b_win_0;  assign b_win_s[1] = b_win_1;  assign b_win_s[2] = b_win_2;
    assign b_win_s[3] = b_win_3;  assign b_win_s[4] = b_win_4;  assign b_win_s[5] = b_win_5;
    assign b_win_s[6] = b_win_6;  assign b_win_s[7] = b_win_7;  assign b_win_s[8] = b_win_8;

    task automatic model_accept(input logic [31:0] d);
        img[m_r][m_c] = d;
        exp_valid = (m_r >= 2) && (m_c >= 2);
        exp_done  = (m_r == H - 1) && (m_c == W - 1);
        if (exp_valid)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    exp_win[3*i + j] = img[m_r - 2 + i][m_c - 2 + j];
        m_c++;
        if (m_c == W) begin
            m_c = 0;
            m_r++;
            if (m_r == H) m_r = 0;
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (v) model_accept(d);
        else begin
            exp_valid = 0;
            exp_done  = 0;
        end
    endtask

    task automatic do_reset(input bit v);
        rst        = 1'b1;
        in_valid   = v;
        in_data    = $urandom;
        b_in_valid = v;
        b_in_data  = $urandom;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        in_valid   = 1'b0;
        b_in_valid = 1'b0;
        m_r = 0;
        m_c = 0;
        exp_valid = 0;
        exp_done  = 0;
    endtask

    task automatic test_reset();
        int nz;
        do_reset(1'b1);
        nz = 0;
        for (int k = 0; k < 9; k++) if (win_s[k] !== 32'd0) nz++;
        n_total++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || nz != 0)
            $display("FAIL reset_state got valid=%b done=%b nonzero_taps=%0d exp 0/0/0", out_valid, frame_done, nz);
        else n_pass++;
        nz = 0;
        for (int k = 0; k < 9; k++) if (b_win_s[k] !== 32'd0) nz++;
        n_total++;
        if (b_out_valid !== 1'b0 || b_frame_done !== 1'b0 || nz != 0)
            $display("FAIL reset_state_big got valid=%b done=%b nonzero_taps=%0d exp 0/0/0", b_out_valid, b_frame_done, nz);
        else n_pass++;
    endtask

    // one continuous frame of 5r+c+1 values; also covers the row-wrap pixels
    task automatic test_continuous(input string name);
        logic [31:0] first_c [9];
        logic [31:0] last_c  [9];
        int pulses, first_px, wrap_hits, bad_k;
        logic [31:0] v;
        first_c = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
        last_c  = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
        pulses = 0; first_px = -1; wrap_hits = 0;
        for (int idx = 0; idx < W*H; idx++) begin
            v = 32'(idx + 1);
            drive(1'b1, v);
            n_total++;
            if (out_valid !== exp_valid || frame_done !== exp_done)
                $display("FAIL %s_strobe px=%0d got valid=%b done=%b exp valid=%b done=%b",
                         name, v, out_valid, frame_done, exp_valid, exp_done);
            else n_pass++;
            if (out_valid === 1'b1) begin
                pulses++;
                if (first_px < 0) first_px = int'(v);
                if (v == 11 || v == 12 || v == 16 || v == 17 || v == 21 || v == 22) wrap_hits++;
            end
            if (exp_valid) begin
                bad_k = -1;
                for (int k = 0; k < 9; k++) if (win_s[k] !== exp_win[k] && bad_k < 0) bad_k = k;
                n_total++;
                if (bad_k >= 0)
                    $display("FAIL %s_window px=%0d tap=%0d got=%0d exp=%0d", name, v, bad_k, win_s[bad_k], exp_win[bad_k]);
                else n_pass++;
            end
            if (v == 13 || v == 25) begin
                bad_k = -1;
                for (int k = 0; k < 9; k++)
                    if (win_s[k] !== ((v == 13) ? first_c[k] : last_c[k]) && bad_k < 0) bad_k = k;
                n_total++;
                if (bad_k >= 0)
                    $display("FAIL %s_fixed_window px=%0d tap=%0d got=%0d", name, v, bad_k, win_s[bad_k]);
                else n_pass++;
            end
        end
        n_total++;
        if (pulses != 9) $display("FAIL %s_pulse_count got=%0d exp=9", name, pulses);
        else n_pass++;
        n_total++;
        if (first_px != 13) $display("FAIL %s_first_pulse got_px=%0d exp_px=13", name, first_px);
        else n_pass++;
        n_total++;
        if (wrap_hits != 0) $display("FAIL %s_row_wrap got=%0d exp=0", name, wrap_hits);
        else n_pass++;
    endtask

    task automatic test_gaps();
        int pulses, gap, bad_k, gap_bad;
        logic [31:0] v;
        pulses = 0; gap_bad = 0;
        for (int idx = 0; idx < W*H; idx++) begin
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, $urandom);
                if (out_valid !== 1'b0 || frame_done !== 1'b0) gap_bad++;
            end
            v = 32'(idx + 1);
            drive(1'b1, v);
            n_total++;
            if (out_valid !== exp_valid || frame_done !== exp_done)
                $display("FAIL gaps_strobe px=%0d got valid=%b done=%b exp valid=%b done=%b",
                         v, out_valid, frame_done, exp_valid, exp_done);
            else n_pass++;
            if (out_valid === 1'b1) pulses++;
            if (exp_valid) begin
                bad_k = -1;
                for (int k = 0; k < 9; k++) if (win_s[k] !== exp_win[k] && bad_k < 0) bad_k = k;
                n_total++;
                if (bad_k >= 0)
                    $display("FAIL gaps_window px=%0d tap=%0d got=%0d exp=%0d", v, bad_k, win_s[bad_k], exp_win[bad_k]);
                else n_pass++;
            end
        end
        n_total++;
        if (gap_bad != 0) $display("FAIL gaps_idle_strobe got=%0d exp=0", gap_bad);
        else n_pass++;
        n_total++;
        if (pulses != 9) $display("FAIL gaps_pulse_count got=%0d exp=9", pulses);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pulses [2];
        int first_px2, mixed, bad_win, bad_strobe;
        logic [31:0] v;
        bit lo, hi;
        pulses = '{0, 0}; first_px2 = -1; mixed = 0; bad_win = 0; bad_strobe = 0;
        for (int f = 0; f < 2; f++) begin
            for (int idx = 0; idx < W*H; idx++) begin
                v = 32'(idx + 1 + 100*f);
                drive(1'b1, v);
                if (out_valid !== exp_valid || frame_done !== exp_done) bad_strobe++;
                if (out_valid === 1'b1) begin
                    pulses[f]++;
                    if (f == 1 && first_px2 < 0) first_px2 = int'(v);
                    lo = 0; hi = 0;
                    for (int k = 0; k < 9; k++) begin
                        if (win_s[k] <= 32'd25) lo = 1;
                        else hi = 1;
                    end
                    if (lo && hi) mixed++;
                end
                if (exp_valid)
                    for (int k = 0; k < 9; k++) if (win_s[k] !== exp_win[k]) bad_win++;
            end
        end
        n_total++;
        if (bad_strobe != 0) $display("FAIL b2b_strobes got=%0d bad cycles exp=0", bad_strobe);
        else n_pass++;
        n_total++;
        if (bad_win != 0) $display("FAIL b2b_windows got=%0d bad taps exp=0", bad_win);
        else n_pass++;
        n_total++;
        if (pulses[0] != 9 || pulses[1] != 9)
            $display("FAIL b2b_pulse_count got=%0d,%0d exp=9,9", pulses[0], pulses[1]);
        else n_pass++;
        n_total++;
        if (first_px2 != 113) $display("FAIL b2b_second_start got_px=%0d exp_px=113", first_px2);
        else n_pass++;
        n_total++;
        if (mixed != 0) $display("FAIL b2b_mixed_frames got=%0d exp=0", mixed);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nz;
        for (int idx = 0; idx < 17; idx++) drive(1'b1, 32'(idx + 1));
        do_reset(1'b0);
        nz = 0;
        for (int k = 0; k < 9; k++) if (win_s[k] !== 32'd0) nz++;
        n_total++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || nz != 0)
            $display("FAIL midreset_state got valid=%b done=%b nonzero_taps=%0d exp 0/0/0", out_valid, frame_done, nz);
        else n_pass++;
        test_continuous("after_reset");
    endtask

    task automatic test_big_frame();
        logic [31:0] bimg [BH][BW];
        logic [31:0] d;
        int wins, dones, bad_strobe, bad_win, held_bad;
        bit ev, ed;
        for (int f = 0; f < 2; f++) begin
            wins = 0; dones = 0; bad_strobe = 0; bad_win = 0;
            for (int r = 0; r < BH; r++) begin
                for (int c = 0; c < BW; c++) begin
                    d = $urandom;
                    b_in_valid = 1'b1;
                    b_in_data  = d;
                    @(posedge clk);
                    #1;
                    b_in_valid = 1'b0;
                    bimg[r][c] = d;
                    ev = (r >= 2) && (c >= 2);
                    ed = (r == BH - 1) && (c == BW - 1);
                    if (b_out_valid !== ev || b_frame_done !== ed) bad_strobe++;
                    if (b_out_valid === 1'b1) wins++;
                    if (b_frame_done === 1'b1) dones++;
                    if (ev)
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                if (b_win_s[3*i + j] !== bimg[r - 2 + i][c - 2 + j]) bad_win++;
                end
            end
            n_total++;
            if (wins != 676) $display("FAIL big_window_count frame=%0d got=%0d exp=676", f, wins);
            else n_pass++;
            n_total++;
            if (dones != 1) $display("FAIL big_frame_done_count frame=%0d got=%0d exp=1", f, dones);
            else n_pass++;
            n_total++;
            if (bad_strobe != 0 || bad_win != 0)
                $display("FAIL big_content frame=%0d got bad_strobes=%0d bad_taps=%0d exp 0/0", f, bad_strobe, bad_win);
            else n_pass++;
        end
        // reset held while data is offered: nothing may come out
        held_bad = 0;
        for (int n = 0; n < 40; n++) begin
            rst        = 1'b1;
            b_in_valid = 1'b1;
            b_in_data  = $urandom;
            in_valid   = 1'b1;
            in_data    = $urandom;
            @(posedge clk);
            #1;
            if (b_out_valid !== 1'b0 || out_valid !== 1'b0 ||
                b_frame_done !== 1'b0 || frame_done !== 1'b0) held_bad++;
        end
        rst = 1'b0; b_in_valid = 1'b0; in_valid = 1'b0;
        m_r = 0; m_c = 0;
        n_total++;
        if (held_bad != 0) $display("FAIL rst_held_with_valid got=%0d strobe cycles exp=0", held_bad);
        else n_pass++;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_continuous("continuous");
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_big_frame();
        // after holding reset with data, the next pixel must be (0,0) of a new frame
        test_continuous("after_held_reset");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
